// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg
// Shared definitions for the instruction-fetch buffer:
//   - `RESET_PC_DEFAULT : default first fetch address after reset
//   - fetch_entry_t     : one decoded-stage entry {inst, pc}
//   - cntWidth()        : bit width of an occupancy counter that must
//                         represent 0..depth inclusive

`ifndef RESET_PC_DEFAULT
`define RESET_PC_DEFAULT 32'h0040_0000
`endif

package fetch_buffer_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT_C = `RESET_PC_DEFAULT;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // A counter for a structure of 'depth' slots must also hold 'depth'
  // itself (full), hence depth+1 distinct values.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// sync_fifo
// Small synchronous FIFO with flush, used both for the prefetch queue and
// for the in-flight PC queue.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, wdata  : write an entry (ignored when full and not popping)
//   pop          : remove the head (ignored when empty)
//   flush        : discard every entry, takes priority over push/pop
//   rdata        : head entry, forced to zero while empty
//   count        : number of valid entries, 0..DEPTH

module sync_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [cntWidth(DEPTH)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cntWidth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  // Pointers wrap explicitly so DEPTH need not fill the pointer range.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop on an empty FIFO is meaningless, so it is dropped here; a push is
  // refused only when full and nothing leaves on the same edge.
  assign doPop  = pop && (count_q != '0);
  assign doPush = push && ((count_q != CW'(DEPTH)) || doPop);

  // Next-state for pointers and occupancy; flush empties the FIFO outright.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = nextPtr(wrPtr_q);
      if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
      if (doPush && !doPop)      count_d = count_q + CW'(1);
      else if (!doPush && doPop) count_d = count_q - CW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (doPush && !flush) mem_q[wrPtr_q] <= wdata;
  end

  assign rdata = (count_q != '0) ? mem_q[rdPtr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Instruction-fetch stage: issues sequential word-aligned fetch requests,
// queues in-order responses in a prefetch FIFO and presents {inst, pc} to
// decode. A redirect flushes the queue and drops responses still in flight.
// Optional macro FETCH_BUF_BYPASS_EN forwards a response straight to the
// outputs when the FIFO is empty and nothing is being discarded.
// Ports:
//   clock, reset                       : clock, async active-high reset
//   redirect_valid, redirect_pc        : restart fetch at redirect_pc & ~3
//   imem_req_valid/ready, imem_req_addr: request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data      : in-order responses, never stalled
//   out_valid/ready, out_inst, out_pc  : head of the prefetch FIFO to decode

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = `RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam int CW = cntWidth(DEPTH);
  localparam int QW = cntWidth(MAX_OUTSTANDING);

  logic [31:0]  fetchPc_q, fetchPc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] inflight, inflightNext;
  logic [CW-1:0] fifoCount;
  logic [QW-1:0] pcqCount;
  logic [31:0]   pcqHead;
  logic          reqFire, rspDrop, fifoPush;
  fetch_entry_t  pushEntry, headEntry;

  // Every accepted request owns a PC-queue slot until its response returns,
  // so the PC queue occupancy is exactly the in-flight count.
  assign inflight = CW'(pcqCount);

  // Credit: a request is only issued when a FIFO slot is guaranteed for its
  // response, which is why responses never need backpressure.
  assign imem_req_valid = !reset && !redirect_valid
                       && (({1'b0, fifoCount} + {1'b0, inflight}) < (CW+1)'(DEPTH))
                       && (inflight < CW'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetchPc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // Responses belonging to the pre-redirect stream are dropped, including
  // one arriving in the redirect cycle itself.
  assign rspDrop      = redirect_valid || (discard_q != '0);
  assign inflightNext = inflight + CW'(reqFire) - CW'(imem_rsp_valid);
  assign pushEntry    = '{inst: imem_rsp_data, pc: pcqHead};

  // Fetch address and discard bookkeeping. On redirect the discard count is
  // reloaded from the post-edge in-flight count, so back-to-back redirects
  // simply recompute it rather than accumulating by hand.
  always_comb begin
    fetchPc_d = fetchPc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      fetchPc_d = redirect_pc & ~32'd3;
      discard_d = inflightNext;
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + 32'd4;
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  // Control registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchPc_q <= RESET_PC;
      discard_q <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      discard_q <= discard_d;
    end
  end

`ifdef FETCH_BUF_BYPASS_EN
  logic bypassOn;

  // Forward a live response when nothing older is queued; if decode takes it
  // in the same cycle it never needs a FIFO slot.
  assign bypassOn  = !reset && (fifoCount == '0) && (discard_q == '0)
                  && imem_rsp_valid && !redirect_valid;
  assign fifoPush  = imem_rsp_valid && !rspDrop && !(bypassOn && out_ready);
  assign out_valid = bypassOn || (fifoCount != '0);
  assign out_inst  = bypassOn ? imem_rsp_data : headEntry.inst;
  assign out_pc    = bypassOn ? pcqHead       : headEntry.pc;
`else
  assign fifoPush  = imem_rsp_valid && !rspDrop;
  assign out_valid = (fifoCount != '0);
  assign out_inst  = headEntry.inst;
  assign out_pc    = headEntry.pc;
`endif

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) fetchFifo (
    .clock (clock),
    .reset (reset),
    .push  (fifoPush),
    .pop   (out_ready),
    .flush (redirect_valid),
    .wdata (pushEntry),
    .rdata (headEntry),
    .count (fifoCount)
  );

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) pcQueue (
    .clock (clock),
    .reset (reset),
    .push  (reqFire),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .wdata (fetchPc_q),
    .rdata (pcqHead),
    .count (pcqCount)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer
// Self-checking bench for fetch_buffer: a randomized instruction memory with
// configurable latency and a queue-based reference model of the fetch stream.

module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  always #5 clock = ~clock;

  fetch_buffer #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  // Memory/model request record: address the DUT asked for, the address the
  // model expected, the cycle it may be answered, and its fetch epoch.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] expAddr;
    int          due;
    int          epoch;
  } memReq_t;

  memReq_t      memQ[$];
  fetch_entry_t outQ[$];

  int          cyc, epoch, latency, readyPct, outReadyPct, rspStallPct;
  int          nCompared, nMismatch, acceptedCnt, firstFireCyc, firstOutCyc;
  logic [31:0] expPc, salt, firstPc;
  bit          captureFirst;

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatch++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs; the memory answers its oldest request once due.
  task automatic applyStimulus();
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    imem_req_ready = (int'($urandom_range(0, 99)) < readyPct);
    out_ready      = (int'($urandom_range(0, 99)) < outReadyPct);
    if (!reset && memQ.size() != 0 && memQ[0].due <= cyc
        && int'($urandom_range(0, 99)) >= rspStallPct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instOf(memQ[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic setMode(input int lat, input int rdy, input int ordy);
    latency     = lat;
    readyPct    = rdy;
    outReadyPct = ordy;
    applyStimulus();
  endtask

  // Check the settled outputs of the current cycle, then advance the model
  // across the coming edge and drive the next cycle.
  task automatic runCycle();
    logic    expReqValid, expOutValid, pop, fire;
    memReq_t m;
    @(negedge clock);
    expReqValid = !redirect_valid && (outQ.size() + memQ.size() < DEPTH) && (memQ.size() < MAXO);
    expOutValid = (outQ.size() != 0);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(expReqValid));
    checkOutput("out_valid", 32'(out_valid), 32'(expOutValid));
    if (expOutValid) begin
      checkOutput("out_pc", out_pc, outQ[0].pc);
      checkOutput("out_inst", out_inst, outQ[0].inst);
    end
    fire = imem_req_valid && imem_req_ready;
    pop  = expOutValid && out_ready;
    if (out_valid && firstFireCyc >= 0 && firstOutCyc < 0) firstOutCyc = cyc;
    if (fire && firstFireCyc < 0) firstFireCyc = cyc;
    if (pop) begin
      if (captureFirst) begin
        firstPc      = out_pc;
        captureFirst = 1'b0;
      end
      outQ.delete(0);
    end
    if (imem_rsp_valid) begin
      m = memQ.pop_front();
      if (m.epoch == epoch && !redirect_valid)
        outQ.push_back('{inst: instOf(m.expAddr), pc: m.expAddr});
    end
    if (fire) begin
      checkOutput("req_addr", imem_req_addr, expPc);
      memQ.push_back('{addr: imem_req_addr, expAddr: expPc, due: cyc + latency, epoch: epoch});
      expPc = expPc + 32'd4;
      acceptedCnt++;
      checkOutput("inflight_max", 32'(memQ.size() <= MAXO), 32'd1);
    end
    if (redirect_valid) begin
      outQ.delete();
      epoch++;
      expPc = redirect_pc & ~32'd3;
    end
    @(posedge clock);
    cyc++;
    #1;
    applyStimulus();
  endtask

  task automatic doRedirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    runCycle();
  endtask

  // Assert reset between edges and confirm outputs fall without a clock edge.
  task automatic doReset();
    reset = 1'b1;
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_inst", out_inst, 32'd0);
    memQ.delete();
    outQ.delete();
    epoch++;
    expPc        = RPC;
    acceptedCnt  = 0;
    firstFireCyc = -1;
    firstOutCyc  = -1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus();
  endtask

  // Directed phases followed by a long randomized run.
  initial begin
    int  waitCnt;
    bit  filled;
    nCompared = 0; nMismatch = 0; cyc = 0; epoch = 0;
    salt = $urandom; firstPc = '0; captureFirst = 1'b0;
    latency = 1; readyPct = 100; outReadyPct = 100; rspStallPct = 0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; out_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    @(posedge clock);
    #1;
    doReset();

    $display("[TB] streaming after reset");
    setMode(1, 100, 100);
    captureFirst = 1'b1;
    repeat (20) runCycle();
    checkOutput("first_out_pc", firstPc, RPC);
    checkOutput("first_latency", 32'(firstOutCyc - firstFireCyc), 32'd2);

    $display("[TB] decode stalled");
    doReset();
    setMode(1, 100, 0);
    repeat (12) runCycle();
    #1;
    checkOutput("stall_accepted", 32'(acceptedCnt), 32'd4);
    checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_head_pc", out_pc, RPC);
    setMode(1, 100, 100);
    repeat (12) runCycle();

    $display("[TB] latency 3 with random handshakes");
    setMode(3, 70, 70);
    repeat (80) runCycle();
    setMode(1, 100, 100);
    repeat (10) runCycle();

    $display("[TB] redirect with queued and in-flight work");
    setMode(3, 100, 0);
    filled = 1'b0;
    for (waitCnt = 0; waitCnt < 60 && !filled; waitCnt++) begin
      if (outQ.size() == 2 && memQ.size() == 2) filled = 1'b1;
      else runCycle();
    end
    if (!filled) checkOutput("fill_timeout", 32'(outQ.size()), 32'd2);
    doRedirect(32'h0000_1002);
    captureFirst = 1'b1;
    #1;
    checkOutput("redir_out_valid", 32'(out_valid), 32'd0);
    setMode(1, 100, 100);
    repeat (20) runCycle();
    checkOutput("redir_first_pc", firstPc, 32'h0000_1000);

    $display("[TB] back-to-back redirects");
    setMode(2, 100, 100);
    repeat (3) runCycle();
    doRedirect(32'h0000_0100);
    doRedirect(32'h0000_0200);
    captureFirst = 1'b1;
    repeat (20) runCycle();
    checkOutput("b2b_first_pc", firstPc, 32'h0000_0200);

    $display("[TB] address wrap");
    doRedirect(32'hFFFF_FFFC);
    captureFirst = 1'b1;
    repeat (20) runCycle();
    checkOutput("wrap_first_pc", firstPc, 32'hFFFF_FFFC);

    $display("[TB] randomized run");
    rspStallPct = 20;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0)
        setMode(int'($urandom_range(1, 4)), int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
      if (i == 700) doReset();
      else if ($urandom_range(0, 99) < 3) doRedirect($urandom);
      else runCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
